minute_hour_counter: RTL and testbench

- Downstream stage of the seconds counter in the digital clock.
- Consumes the registered `sec_carry` level, advances minutes and hours, and produces a day-rollover pulse.
- Provides a time-set mode driven by debounced button pulses.
- Runs on the fast system clock; the carry input comes from the slower 1 Hz domain and is synchronised internally.

---
 rtl/clock_pkg.sv | 16 +
 rtl/sync_rise_detect.sv | 34 +++
 rtl/minute_hour_counter.sv | 99 +++++++++
 tb/tb_minute_hour_counter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and default limits for the digital clock's time-keeping blocks.
// The display and alarm blocks import this package as well.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_t;

  localparam int MIN_MAX_DEF  = 59;
  localparam int HOUR_MAX_DEF = 23;
  localparam int MIN_W        = 6;
  localparam int HOUR_W       = 5;

endpackage

// File: rtl/sync_rise_detect.sv
// Brings a slow-domain level into the clk domain and flags its rising edge.
// Every flop resets to 1, so an input already high at reset release never fires.
module sync_rise_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/minute_hour_counter.sv
// Minute/hour stage of the digital clock: advances on synchronised seconds carries
// in RUN and lets the user set hours and minutes with debounced button pulses.
module minute_hour_counter
  import clock_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_MAX     = MIN_MAX_DEF,
  parameter int HOUR_MAX    = HOUR_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sec_carry,
  input  logic              btn_mode,
  input  logic              btn_inc,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic              day_carry,
  output logic [1:0]        mode
);

  logic              carry_rise;
  logic [MIN_W-1:0]  min_q;
  logic [MIN_W-1:0]  min_d;
  logic [HOUR_W-1:0] hour_q;
  logic [HOUR_W-1:0] hour_d;
  logic              day_carry_q;
  logic              day_carry_d;
  mode_t             mode_q;
  mode_t             mode_d;
  logic              min_at_max;
  logic              hour_at_max;

  sync_rise_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_carry_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(sec_carry),
    .rise    (carry_rise)
  );

  assign min_at_max  = (min_q == MIN_W'(MIN_MAX));
  assign hour_at_max = (hour_q == HOUR_W'(HOUR_MAX));

  // Carry edges outside RUN are simply dropped; the detector still tracks history.
  always_comb begin
    min_d       = min_q;
    hour_d      = hour_q;
    day_carry_d = 1'b0;
    mode_d      = mode_q;
    case (mode_q)
      RUN: begin
        if (carry_rise) begin
          if (min_at_max) begin
            min_d = '0;
            if (hour_at_max) begin
              hour_d      = '0;
              day_carry_d = 1'b1;
            end else begin
              hour_d = hour_q + HOUR_W'(1);
            end
          end else begin
            min_d = min_q + MIN_W'(1);
          end
        end
        if (btn_mode) mode_d = SET_HOUR;
      end
      SET_HOUR: begin
        if (btn_inc) hour_d = hour_at_max ? '0 : hour_q + HOUR_W'(1);
        if (btn_mode) mode_d = SET_MIN;
      end
      SET_MIN: begin
        if (btn_inc) min_d = min_at_max ? '0 : min_q + MIN_W'(1);
        if (btn_mode) mode_d = RUN;
      end
      default: mode_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      min_q       <= '0;
      hour_q      <= '0;
      day_carry_q <= 1'b0;
      mode_q      <= RUN;
    end else begin
      min_q       <= min_d;
      hour_q      <= hour_d;
      day_carry_q <= day_carry_d;
      mode_q      <= mode_d;
    end
  end

  assign min       = min_q;
  assign hour      = hour_q;
  assign day_carry = day_carry_q;
  assign mode      = mode_q;

endmodule

// File: tb/tb_minute_hour_counter.sv
// Directed bench for minute_hour_counter: stimulus queues hand-computed expectations
// tagged with the cycle they are due, and a negedge monitor pops and compares them.
module tb_minute_hour_counter;

  logic       clk;
  logic       reset;
  logic       sec_carry;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] min;
  logic [4:0] hour;
  logic       day_carry;
  logic [1:0] mode;

  typedef struct {
    int         due;
    logic [5:0] min;
    logic [4:0] hour;
    logic [1:0] mode;
    logic       dc;
  } exp_t;

  exp_t  sb[$];
  string nameQ[$];
  int    cycle;
  int    testsRun;
  int    testsFailed;
  int    dayPulses;

  minute_hour_counter dut (
    .clk      (clk),
    .reset    (reset),
    .sec_carry(sec_carry),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .min      (min),
    .hour     (hour),
    .day_carry(day_carry),
    .mode     (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string nm, input logic [5:0] em, input logic [4:0] eh,
                             input logic [1:0] emd, input logic edc);
    testsRun++;
    if ({min, hour, mode, day_carry} !== {em, eh, emd, edc}) begin
      testsFailed++;
      $display("[TB] FAIL %s: got min=%0d hour=%0d mode=%0d day_carry=%0d, want min=%0d hour=%0d mode=%0d day_carry=%0d",
               nm, min, hour, mode, day_carry, em, eh, emd, edc);
    end
  endtask

  // Monitor: counts day pulses and compares every expectation that has come due.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (day_carry === 1'b1) dayPulses++;
    while (sb.size() > 0 && sb[0].due <= cycle) begin
      e  = sb.pop_front();
      nm = nameQ.pop_front();
      checkOutput(nm, e.min, e.hour, e.mode, e.dc);
    end
  end

  task automatic expectAt(input int d, input string nm, input int em, input int eh,
                          input int emd, input int edc);
    exp_t e;
    int   idx;
    e.due  = cycle + d;
    e.min  = 6'(em);
    e.hour = 5'(eh);
    e.mode = 2'(emd);
    e.dc   = 1'(edc);
    idx    = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].due > e.due) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
    nameQ.insert(idx, nm);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic m, input logic inc);
    btn_mode = m;
    btn_inc  = inc;
    tick(1);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    dayPulses   = 0;
    reset       = 1'b1;
    sec_carry   = 1'b1;
    btn_mode    = 1'b0;
    btn_inc     = 1'b0;

    // Reset with carry already high, then hold it high.
    #1 reset = 1'b0;
    #1 checkOutput("reset_async", 0, 0, 0, 0);
    tick(3);
    reset = 1'b1;
    expectAt(0, "reset_release", 0, 0, 0, 0);
    expectAt(200, "carry_held_200", 0, 0, 0, 0);
    tick(200);

    // Carry latency and one advance per rising edge.
    sec_carry = 1'b0;
    tick(5);
    sec_carry = 1'b1;
    expectAt(2, "carry_lat_2", 0, 0, 0, 0);
    expectAt(3, "carry_lat_3", 1, 0, 0, 0);
    tick(50);
    expectAt(0, "carry_held_50", 1, 0, 0, 0);
    sec_carry = 1'b0;
    tick(50);
    sec_carry = 1'b1;
    expectAt(3, "second_rise", 2, 0, 0, 0);
    tick(50);
    sec_carry = 1'b0;
    tick(5);

    // Set hour with wrap, then set minutes with wrap.
    applyStimulus(1'b1, 1'b0);
    expectAt(0, "mode_set_hour", 2, 0, 1, 0);
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b0, 1'b1);
      expectAt(0, $sformatf("hour_inc%0d", i), 2, (i + 1) % 24, 1, 0);
    end
    applyStimulus(1'b1, 1'b0);
    expectAt(0, "mode_set_min", 2, 1, 2, 0);
    for (int i = 0; i < 61; i++) begin
      applyStimulus(1'b0, 1'b1);
      expectAt(0, $sformatf("min_inc%0d", i), (3 + i) % 60, 1, 2, 0);
    end
    sec_carry = 1'b1;
    tick(10);
    sec_carry = 1'b0;
    tick(5);
    expectAt(0, "carry_dropped_set_min", 3, 1, 2, 0);
    applyStimulus(1'b1, 1'b0);
    expectAt(0, "mode_run", 3, 1, 0, 0);
    tick(10);
    expectAt(0, "no_stale_edge", 3, 1, 0, 0);
    applyStimulus(1'b0, 1'b1);
    expectAt(0, "inc_ignored_run", 3, 1, 0, 0);

    // Preset 23:59 and roll the day.
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 22; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 56; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    expectAt(0, "preset_2359", 59, 23, 0, 0);
    sec_carry = 1'b1;
    expectAt(2, "rollover_before", 59, 23, 0, 0);
    expectAt(3, "rollover_pulse", 0, 0, 0, 1);
    expectAt(4, "rollover_after", 0, 0, 0, 0);
    tick(10);
    sec_carry = 1'b0;
    tick(5);

    // Simultaneous button and carry interactions.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    expectAt(0, "mode_inc_same_cycle", 0, 1, 2, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
    expectAt(0, "preset_0105", 5, 1, 2, 0);
    applyStimulus(1'b1, 1'b0);
    sec_carry = 1'b1;
    tick(2);
    applyStimulus(1'b1, 1'b0);
    expectAt(0, "carry_with_mode", 6, 1, 1, 0);
    tick(20);
    sec_carry = 1'b0;
    tick(5);
    sec_carry = 1'b1;
    tick(10);
    sec_carry = 1'b0;
    tick(5);
    expectAt(0, "carry_dropped_set_hour", 6, 1, 1, 0);
    applyStimulus(1'b1, 1'b0);
    sec_carry = 1'b1;
    tick(2);
    applyStimulus(1'b0, 1'b1);
    expectAt(0, "carry_with_inc_set_min", 7, 1, 2, 0);
    tick(10);
    sec_carry = 1'b0;
    tick(5);
    expectAt(0, "single_inc_only", 7, 1, 2, 0);

    // Reset mid-operation at 12:34 with a carry in flight.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 27; i++) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    expectAt(0, "preset_1234", 34, 12, 0, 0);
    tick(1);
    sec_carry = 1'b1;
    tick(1);
    #2 reset = 1'b0;
    #1 checkOutput("reset_async_mid", 0, 0, 0, 0);
    tick(2);
    reset = 1'b1;
    expectAt(0, "reset_release_mid", 0, 0, 0, 0);
    expectAt(20, "no_advance_after_reset", 0, 0, 0, 0);
    tick(20);
    sec_carry = 1'b0;
    tick(5);

    testsRun++;
    if (dayPulses != 1) begin
      testsFailed++;
      $display("[TB] FAIL day_pulse_count: got %0d, want 1", dayPulses);
    end
    testsRun++;
    if (sb.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL pending_expectations: got %0d left, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
